// File: rtl/clock_set_controller.sv
// Time-set sequencer for the digital clock: hour/minute edit, blink,
// auto-repeat, inactivity abort and a one-cycle load strobe.
module clock_set_controller #(
    parameter int TIMEOUT_TICKS = 10,
    parameter int HOLD_TICKS    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hours,
    input  logic [5:0] cur_minutes,
    output logic       run_en,
    output logic       load_en,
    output logic [4:0] load_hours,
    output logic [5:0] load_minutes,
    output logic [4:0] disp_hours,
    output logic [5:0] disp_minutes,
    output logic       blank_hr,
    output logic       blank_min,
    output logic       editing
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t     state, state_n;
    logic       mode_prev, inc_prev;
    logic [4:0] edit_hr;
    logic [5:0] edit_min;
    logic       blink_phase;
    logic [5:0] tmo_cnt;
    logic [3:0] hold_cnt;

    logic mode_rise, inc_rise, rep_ev, inc_ev, tmo_hit;
    logic cap, hr_inc, min_inc, commit_ld;
    logic blink_clr, blink_tog, tmo_clr, tmo_inc;

    assign mode_rise = btn_mode & ~mode_prev;
    assign inc_rise  = btn_inc & ~inc_prev;
    assign rep_ev    = btn_inc & tick_1hz &
                       (hold_cnt == 4'(HOLD_TICKS));
    assign inc_ev    = inc_rise | rep_ev;
    assign tmo_hit   = tick_1hz & ~inc_rise &
                       (tmo_cnt == 6'(TIMEOUT_TICKS - 1));

    // State register; reset always lands in RUN with no load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_n;
    end

    // Next state, datapath controls and registered-state outputs.
    always_comb begin
        state_n      = state;
        cap          = 1'b0;
        hr_inc       = 1'b0;
        min_inc      = 1'b0;
        commit_ld    = 1'b0;
        blink_clr    = 1'b0;
        blink_tog    = 1'b0;
        tmo_clr      = 1'b0;
        tmo_inc      = 1'b0;
        run_en       = 1'b0;
        load_en      = 1'b0;
        editing      = 1'b0;
        blank_hr     = 1'b0;
        blank_min    = 1'b0;
        disp_hours   = edit_hr;
        disp_minutes = edit_min;
        unique case (state)
            RUN: begin
                run_en       = 1'b1;
                disp_hours   = cur_hours;
                disp_minutes = cur_minutes;
                if (mode_rise) begin
                    cap       = 1'b1;
                    blink_clr = 1'b1;
                    tmo_clr   = 1'b1;
                    state_n   = SET_HR;
                end
            end
            SET_HR: begin
                editing  = 1'b1;
                blank_hr = blink_phase;
                if (mode_rise) begin
                    blink_clr = 1'b1;
                    tmo_clr   = 1'b1;
                    state_n   = SET_MIN;
                end else if (tmo_hit) begin
                    state_n = RUN;
                end else begin
                    if (inc_ev) begin
                        hr_inc    = 1'b1;
                        blink_clr = 1'b1;
                    end else if (tick_1hz) begin
                        blink_tog = 1'b1;
                    end
                    if (inc_rise)      tmo_clr = 1'b1;
                    else if (tick_1hz) tmo_inc = 1'b1;
                end
            end
            SET_MIN: begin
                editing   = 1'b1;
                blank_min = blink_phase;
                if (mode_rise) begin
                    commit_ld = 1'b1;
                    tmo_clr   = 1'b1;
                    state_n   = COMMIT;
                end else if (tmo_hit) begin
                    state_n = RUN;
                end else begin
                    if (inc_ev) begin
                        min_inc   = 1'b1;
                        blink_clr = 1'b1;
                    end else if (tick_1hz) begin
                        blink_tog = 1'b1;
                    end
                    if (inc_rise)      tmo_clr = 1'b1;
                    else if (tick_1hz) tmo_inc = 1'b1;
                end
            end
            COMMIT: begin
                load_en = 1'b1;
                state_n = RUN;
            end
            default: state_n = RUN;
        endcase
    end

    // Button history, edit fields, blink, timeout and hold counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_prev    <= 1'b0;
            inc_prev     <= 1'b0;
            edit_hr      <= '0;
            edit_min     <= '0;
            blink_phase  <= 1'b0;
            tmo_cnt      <= '0;
            hold_cnt     <= '0;
            load_hours   <= '0;
            load_minutes <= '0;
        end else begin
            mode_prev <= btn_mode;
            inc_prev  <= btn_inc;
            if (!btn_inc)
                hold_cnt <= '0;
            else if (tick_1hz && hold_cnt != 4'(HOLD_TICKS))
                hold_cnt <= hold_cnt + 4'd1;
            if (cap) begin
                edit_hr  <= cur_hours;
                edit_min <= cur_minutes;
            end
            if (hr_inc)
                edit_hr <= (edit_hr == 5'd23) ? 5'd0 : edit_hr + 5'd1;
            if (min_inc)
                edit_min <= (edit_min == 6'd59) ? 6'd0 : edit_min + 6'd1;
            if (blink_clr)      blink_phase <= 1'b0;
            else if (blink_tog) blink_phase <= ~blink_phase;
            if (tmo_clr)      tmo_cnt <= '0;
            else if (tmo_inc) tmo_cnt <= tmo_cnt + 6'd1;
            if (commit_ld) begin
                load_hours   <= edit_hr;
                load_minutes <= edit_min;
            end
        end
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: edit, wrap, auto-repeat,
// timeout abort, mode/inc collision and mid-edit reset.
module tb_clock_set_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] cur_hours = '0;
    logic [5:0] cur_minutes = '0;
    logic       run_en, load_en, blank_hr, blank_min, editing;
    logic [4:0] load_hours, disp_hours;
    logic [5:0] load_minutes, disp_minutes;

    int n_chk = 0;
    int n_pass = 0;
    int load_cnt = 0;
    int load_base;

    clock_set_controller #(.TIMEOUT_TICKS(10), .HOLD_TICKS(2)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hours(cur_hours), .cur_minutes(cur_minutes),
        .run_en(run_en), .load_en(load_en),
        .load_hours(load_hours), .load_minutes(load_minutes),
        .disp_hours(disp_hours), .disp_minutes(disp_minutes),
        .blank_hr(blank_hr), .blank_min(blank_min), .editing(editing)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (load_en) load_cnt <= load_cnt + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        step();
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        step();
        btn_inc = 1'b0;
        step();
    endtask

    task automatic one_tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        step();
    endtask

    initial begin
        // 1: reset state and entry to hour edit
        cur_hours = 5'd13;
        cur_minutes = 6'd45;
        do_reset();
        check("rst_run_en", run_en, 1);
        check("rst_editing", editing, 0);
        check("rst_load_en", load_en, 0);
        check("rst_load_hours", load_hours, 0);
        check("rst_load_minutes", load_minutes, 0);
        check("rst_disp_h", disp_hours, 13);
        btn_mode = 1'b1;
        step();
        check("t1_editing", editing, 1);
        check("t1_run_en", run_en, 0);
        check("t1_disp_h", disp_hours, 13);
        check("t1_disp_m", disp_minutes, 45);
        check("t1_blank_hr", blank_hr, 0);
        btn_mode = 1'b0;
        step();

        // 2: wrap both fields and commit
        cur_hours = 5'd22;
        cur_minutes = 6'd58;
        do_reset();
        press_mode();
        check("t2_hr_cap", disp_hours, 22);
        press_inc();
        check("t2_hr_23", disp_hours, 23);
        press_inc();
        check("t2_hr_wrap", disp_hours, 0);
        press_mode();
        check("t2_min_cap", disp_minutes, 58);
        check("t2_hr_kept", disp_hours, 0);
        press_inc();
        check("t2_min_59", disp_minutes, 59);
        press_inc();
        check("t2_min_wrap", disp_minutes, 0);
        load_base = load_cnt;
        btn_mode = 1'b1;
        step();
        check("t2_load_en", load_en, 1);
        check("t2_load_h", load_hours, 0);
        check("t2_load_m", load_minutes, 0);
        check("t2_commit_run", run_en, 0);
        btn_mode = 1'b0;
        step();
        check("t2_load_off", load_en, 0);
        check("t2_run_after", run_en, 1);
        check("t2_load_h_hold", load_hours, 0);
        check("t2_load_pulses", load_cnt - load_base, 1);

        // 3: hold-to-repeat on minutes
        cur_hours = 5'd5;
        cur_minutes = 6'd10;
        do_reset();
        press_mode();
        press_mode();
        btn_inc = 1'b1;
        step();
        check("t3_edge", disp_minutes, 11);
        for (int i = 1; i <= 6; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            step();
            check($sformatf("t3_tick%0d", i), disp_minutes,
                  (i <= 2) ? 11 : 11 + (i - 2));
            if (i == 1) check("t3_blink1", blank_min, 1);
        end
        check("t3_no_timeout", editing, 1);
        check("t3_blink_forced", blank_min, 0);
        btn_inc = 1'b0;
        step();

        // 4: inactivity abort
        cur_hours = 5'd7;
        cur_minutes = 6'd30;
        do_reset();
        load_base = load_cnt;
        press_mode();
        for (int i = 1; i <= 9; i++) one_tick();
        check("t4_still_edit", editing, 1);
        one_tick();
        check("t4_abort", editing, 0);
        check("t4_run_en", run_en, 1);
        check("t4_no_load", load_cnt - load_base, 0);
        cur_hours = 5'd8;
        cur_minutes = 6'd31;
        #1;
        check("t4_disp_h", disp_hours, 8);
        check("t4_disp_m", disp_minutes, 31);

        // 5: mode and inc rising together
        cur_hours = 5'd4;
        cur_minutes = 6'd20;
        do_reset();
        press_mode();
        one_tick();
        check("t5_blink_on", blank_hr, 1);
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        step();
        check("t5_editing", editing, 1);
        check("t5_hr_same", disp_hours, 4);
        check("t5_blank_hr", blank_hr, 0);
        check("t5_blank_min", blank_min, 0);
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        step();
        one_tick();
        check("t5_in_min", blank_min, 1);
        check("t5_min_same", disp_minutes, 20);

        // 6: reset mid-edit
        cur_hours = 5'd9;
        cur_minutes = 6'd15;
        do_reset();
        load_base = load_cnt;
        press_mode();
        press_mode();
        press_inc();
        press_inc();
        press_inc();
        check("t6_min_18", disp_minutes, 18);
        reset = 1'b1;
        #1;
        check("t6_rst_run", run_en, 1);
        check("t6_rst_edit", editing, 0);
        step();
        reset = 1'b0;
        step();
        check("t6_no_load", load_cnt - load_base, 0);
        check("t6_load_en", load_en, 0);
        cur_hours = 5'd11;
        cur_minutes = 6'd40;
        press_mode();
        check("t6_cap_h", disp_hours, 11);
        check("t6_cap_m", disp_minutes, 40);
        check("t6_cap_edit", editing, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Time-set sequencer for the Digital_Clock datapath.
- Takes two synchronous, debounced push-button levels (mode, inc) and a 1 Hz tick enable.
- Walks the user through hour-edit and minute-edit, then issues a one-cycle load of the edited time into the timekeeper.
- Gates the timekeeper run enable, selects the hours/minutes shown on the 7-segment display, and drives per-field blanking for blink.

Parameters:
- TIMEOUT_TICKS, 10: number of tick_1hz pulses with no button edge after which an edit aborts (range 2..63).
- HOLD_TICKS, 2: number of ticks btn_inc must be held after its rising edge before auto-repeat starts (range 1..15).

Ports:
- clk  in  1  system clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick_1hz  in  1  one-clk-wide 1 Hz enable pulse.
- btn_mode  in  1  mode button level, synchronous and debounced.
- btn_inc  in  1  increment button level, synchronous and debounced.
- cur_hours  in  5  live hours from the timekeeper, 0..23.
- cur_minutes  in  6  live minutes from the timekeeper, 0..59.
- run_en  out  1  timekeeper count enable.
- load_en  out  1  one-cycle load strobe to the timekeeper; seconds load to 0.
- load_hours  out  5  hours value to load.
- load_minutes  out  6  minutes value to load.
- disp_hours  out  5  hours to display.
- disp_minutes  out  6  minutes to display.
- blank_hr  out  1  blank the hour digits.
- blank_min  out  1  blank the minute digits.
- editing  out  1  high in SET_HR or SET_MIN.

Behaviour:
- Reset (async) values:
  - state = RUN; run_en = 1.
  - load_en = 0; load_hours = 0; load_minutes = 0.
  - Edit registers edit_hr = 0, edit_min = 0.
  - Button history registers = 0; blink_phase = 0; timeout counter = 0; hold counter = 0.
- Edge detection:
  - mode_rise = btn_mode & ~mode_prev; inc_rise = btn_inc & ~inc_prev.
  - The prev registers update every clk.
  - A rise acts on the same clk edge it is first seen.
- If mode_rise and an increment event occur in the same cycle, mode wins and the increment is dropped.
- States and transitions:
  - RUN:
    - Outputs: run_en = 1; disp_* = cur_*; blank_* = 0; editing = 0.
    - On mode_rise: edit_hr <= cur_hours, edit_min <= cur_minutes, go to SET_HR.
    - run_en is 0 from the next cycle.
  - SET_HR:
    - Outputs: run_en = 0; disp_* = edit_*; blank_hr = blink_phase; blank_min = 0.
    - On an increment event: edit_hr <= (edit_hr == 23) ? 0 : edit_hr + 1.
    - On mode_rise: go to SET_MIN.
  - SET_MIN:
    - Same as SET_HR, except the minute field is edited: edit_min wraps 59 -> 0, and blank_min = blink_phase.
    - On mode_rise: go to COMMIT.
  - COMMIT (exactly 1 cycle):
    - Outputs: load_en = 1; load_hours = edit_hr; load_minutes = edit_min; run_en = 0.
    - Next state is RUN unconditionally; buttons are ignored in this cycle.
    - load_hours and load_minutes hold their values after COMMIT.
- Increment events, valid in SET_* only:
  - An inc_rise is an event.
  - While btn_inc stays high, the hold counter counts ticks.
  - Once the hold counter reaches HOLD_TICKS, every subsequent tick_1hz with btn_inc high is an event.
  - The hold counter clears when btn_inc is low.
- Blink:
  - blink_phase toggles on each tick_1hz while in SET_*.
  - It clears to 0 on entry to SET_HR and on entry to SET_MIN.
  - Any increment event forces blink_phase = 0, so the digit is visible right after a change.
- Timeout:
  - The counter clears on entering SET_* and on any mode_rise or inc_rise.
  - It counts tick_1hz in SET_*.
  - A tick arriving while the counter = TIMEOUT_TICKS-1, with no button rise in that cycle, aborts to RUN.
  - An abort produces no load_en, and run_en is 1 next cycle.
  - Edit values are discarded on abort.
  - An auto-repeat event does not clear the timeout counter.
- A reset asserted mid-edit returns to RUN immediately and produces no load_en.
- All outputs are functions of registered state only (no input-to-output combinational path), except disp_* in RUN, which pass cur_* through.

Test Plan:
1. Reset, cur = 13:45, pulse mode once -> state SET_HR next cycle; run_en = 0; disp = 13:45; editing = 1.
2. In SET_HR with edit_hr = 22, apply two inc_rise -> edit_hr = 23, then 0. Then mode, then two inc from edit_min = 58 -> edit_min = 59, then 0. Then mode -> load_en high exactly 1 cycle with load_hours = 0, load_minutes = 0; run_en = 1 the following cycle.
3. In SET_MIN, hold btn_inc for 6 ticks with HOLD_TICKS = 2 and edit_min = 10 -> edit_min = 11 on the edge, then 12, 13, 14, 15 on ticks 3..6; no timeout occurs.
4. Enter SET_HR, then apply no buttons for 10 ticks -> state returns to RUN on the 10th tick; load_en never asserts; disp follows cur_*.
5. In SET_HR, raise btn_mode and btn_inc in the same cycle -> state goes to SET_MIN; edit_hr is unchanged; blink_phase = 0.
6. In SET_MIN after 3 increments, assert reset for 1 cycle -> run_en = 1 and editing = 0 immediately; load_en stays 0; after release, mode capture takes the current cur_* values.
